// File: rtl/isa_bus_master_if.sv
// Host request/response and ISA bus signal bundle for isa_bus_master.
// The master modport is the initiator's view; slave is the host/responder side.
interface isa_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_d_oe;
  logic [7:0]  bus_in;
  logic        bus_dir;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_write, req_io, req_addr, req_wdata,
    input  bus_in, bus_dir, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output bus_a, bus_d, bus_d_oe, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
  );

  modport slave (
    output req_valid, req_write, req_io, req_addr, req_wdata,
    output bus_in, bus_dir, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  bus_a, bus_d, bus_d_oe, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
  );
endinterface

// File: rtl/isa_bus_master.sv
// ISA-style bus initiator: one outstanding request sequenced through setup,
// strobe (with bus_rdy wait states and timeout) and hold; all outputs registered.
module isa_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int RDY_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_l,
  isa_bus_master_if.master  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [7:0] SETUP_W  = 8'(SETUP_CYCLES);
  localparam logic [7:0] STROBE_W = 8'(STROBE_CYCLES);
  localparam logic [7:0] HOLD_W   = 8'(HOLD_CYCLES);
  localparam logic [7:0] MAX_W    = 8'(STROBE_CYCLES + RDY_TIMEOUT);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_write;
  logic        r_io;
  logic [7:0]  r_cap_rdata;
  logic        r_cap_to;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_timeout;
  logic [19:0] r_bus_a;
  logic [7:0]  r_bus_d;
  logic        r_bus_d_oe;
  logic        r_ior_l;
  logic        r_iow_l;
  logic        r_memr_l;
  logic        r_memw_l;
  logic        r_aen;
  logic        w_rdy_end;
  logic        w_to_end;

  // Wait-state extension only honoured once the minimum strobe width is met.
  assign w_rdy_end = (r_cnt >= STROBE_W) && bus.bus_rdy;
  assign w_to_end  = (r_cnt == MAX_W);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_io          <= 1'b0;
      r_cap_rdata   <= '0;
      r_cap_to      <= 1'b0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_bus_a       <= '0;
      r_bus_d       <= '0;
      r_bus_d_oe    <= 1'b0;
      r_ior_l       <= 1'b1;
      r_iow_l       <= 1'b1;
      r_memr_l      <= 1'b1;
      r_memw_l      <= 1'b1;
      r_aen         <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && bus.req_valid) begin
            r_write     <= bus.req_write;
            r_io        <= bus.req_io;
            r_bus_a     <= bus.req_io ? {4'h0, bus.req_addr[15:0]} : bus.req_addr;
            r_bus_d     <= bus.req_wdata;
            r_bus_d_oe  <= bus.req_write;
            r_aen       <= 1'b0;
            r_req_ready <= 1'b0;
            r_cnt       <= 8'd1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == SETUP_W) begin
            r_ior_l  <= !(r_io && !r_write);
            r_iow_l  <= !(r_io && r_write);
            r_memr_l <= !(!r_io && !r_write);
            r_memw_l <= !(!r_io && r_write);
            r_cnt    <= 8'd1;
            r_state  <= STROBE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        STROBE: begin
          if (w_rdy_end || w_to_end) begin
            r_cap_to    <= !w_rdy_end;
            r_cap_rdata <= (w_rdy_end && !r_write && bus.bus_dir) ? bus.bus_in : 8'hFF;
            r_ior_l     <= 1'b1;
            r_iow_l     <= 1'b1;
            r_memr_l    <= 1'b1;
            r_memw_l    <= 1'b1;
            r_cnt       <= 8'd1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          if (r_cnt == HOLD_W) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_cap_rdata;
            r_rsp_timeout <= r_cap_to;
            r_req_ready   <= 1'b1;
            r_bus_d_oe    <= 1'b0;
            r_aen         <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.bus_a       = r_bus_a;
  assign bus.bus_d       = r_bus_d;
  assign bus.bus_d_oe    = r_bus_d_oe;
  assign bus.bus_ior_l   = r_ior_l;
  assign bus.bus_iow_l   = r_iow_l;
  assign bus.bus_memr_l  = r_memr_l;
  assign bus.bus_memw_l  = r_memw_l;
  assign bus.bus_aen     = r_aen;
endmodule

// File: tb/tb_isa_bus_master.sv
// Randomized bench for isa_bus_master: each transaction's cycle-by-cycle bus
// timeline is predicted from setup/strobe/hold lengths and the bus_rdy schedule.
module tb_isa_bus_master;
  localparam int S   = 2;
  localparam int T0  = 4;
  localparam int H   = 1;
  localparam int TO  = 64;
  localparam int MAX = T0 + TO;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  time  last_acc = 0;

  always #5 clk = ~clk;

  isa_bus_master_if bus_if ();

  isa_bus_master #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T0),
    .HOLD_CYCLES  (H),
    .RDY_TIMEOUT  (TO)
  ) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus_if.bus_ior_l, bus_if.bus_iow_l, bus_if.bus_memr_l, bus_if.bus_memw_l};
  endfunction

  // rdy_at: first strobe cycle from which bus_rdy is 1 (> MAX means never);
  // abort_c: cycle after acceptance in which reset is pulsed (0 = none).
  task automatic do_txn(input bit w, input bit io, input logic [19:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input bit dir, input int rdy_at, input int abort_c);
    int          t_exp;
    int          end_c;
    int          k;
    int          n;
    int          idx;
    bit          to_exp;
    bit          act;
    logic [7:0]  rd_exp;
    logic [19:0] a_exp;
    logic [3:0]  s_exp;
    t_exp  = (rdy_at > MAX) ? MAX : ((rdy_at < T0) ? T0 : rdy_at);
    to_exp = (rdy_at > MAX);
    end_c  = S + t_exp + H + 1;
    rd_exp = (w || to_exp || !dir) ? 8'hFF : din;
    a_exp  = io ? {4'h0, a[15:0]} : a;
    idx    = io ? (w ? 2 : 3) : (w ? 0 : 1);
    n = 0;
    while (!bus_if.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.req_ready) begin
      check("ready_wait", 32'(bus_if.req_ready), 32'd1);
      return;
    end
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_io    = io;
    bus_if.req_addr  = a;
    bus_if.req_wdata = wd;
    bus_if.bus_in    = din;
    bus_if.bus_dir   = dir;
    @(posedge clk);
    last_acc = $time;
    #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'($urandom);
    bus_if.req_io    = 1'($urandom);
    bus_if.req_addr  = 20'($urandom);
    bus_if.req_wdata = 8'($urandom);
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      act   = (c <= S + t_exp + H);
      s_exp = 4'hF;
      if (c > S && c <= S + t_exp) s_exp[idx] = 1'b0;
      check("strobes", 32'(strobes()), 32'(s_exp));
      check("aen", 32'(bus_if.bus_aen), 32'(!act));
      check("d_oe", 32'(bus_if.bus_d_oe), 32'(act && w));
      if (act) check("bus_a", 32'(bus_if.bus_a), 32'(a_exp));
      if (act && w) check("bus_d", 32'(bus_if.bus_d), 32'(wd));
      check("rsp_valid", 32'(bus_if.rsp_valid), 32'(c == end_c));
      check("req_ready", 32'(bus_if.req_ready), 32'(c == end_c));
      if (c == end_c) begin
        check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(rd_exp));
        check("rsp_timeout", 32'(bus_if.rsp_timeout), 32'(to_exp));
      end
      if (c == abort_c) begin
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        check("abort_strobes", 32'(strobes()), 32'hF);
        check("abort_aen", 32'(bus_if.bus_aen), 32'd1);
        check("abort_ready", 32'(bus_if.req_ready), 32'd0);
        check("abort_valid", 32'(bus_if.rsp_valid), 32'd0);
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          check("abort_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        end
        return;
      end
      k = c - S;
      if (k >= 1 && k < T0) bus_if.bus_rdy = 1'($urandom);
      else                  bus_if.bus_rdy = (k >= rdy_at);
    end
  endtask

  initial begin
    time t1;
    bit  w;
    bit  io;
    int  ra;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_io    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.bus_in    = '0;
    bus_if.bus_dir   = 1'b0;
    bus_if.bus_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    check("rst_timeout", 32'(bus_if.rsp_timeout), 32'd0);
    check("rst_bus_a", 32'(bus_if.bus_a), 32'd0);
    check("rst_bus_d", 32'(bus_if.bus_d), 32'd0);
    check("rst_d_oe", 32'(bus_if.bus_d_oe), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'hF);
    check("rst_aen", 32'(bus_if.bus_aen), 32'd1);
    reset_l = 1'b1;

    do_txn(1'b1, 1'b1, 20'h003D8, 8'h29, 8'h00, 1'b0, 0, 0);
    do_txn(1'b0, 1'b1, 20'hA03DA, 8'h00, 8'hF9, 1'b1, 0, 0);
    do_txn(1'b0, 1'b0, 20'hB8000, 8'h00, 8'h5A, 1'b0, 0, 0);
    do_txn(1'b1, 1'b0, 20'hB8001, 8'h07, 8'h00, 1'b0, 10, 0);
    do_txn(1'b0, 1'b0, 20'hB8002, 8'h00, 8'h33, 1'b1, 999, 0);
    do_txn(1'b0, 1'b1, 20'h003D5, 8'h00, 8'hC4, 1'b1, 0, 0);

    do_txn(1'b1, 1'b0, 20'h12345, 8'hAA, 8'h00, 1'b0, 0, S + 2);
    do_txn(1'b1, 1'b1, 20'h003D4, 8'h0E, 8'h00, 1'b0, 0, 0);
    t1 = last_acc;
    do_txn(1'b0, 1'b1, 20'h003D5, 8'h00, 8'h4C, 1'b1, 0, 0);
    check("b2b_spacing", 32'((last_acc - t1) / 10), 32'(S + T0 + H + 1));

    for (int i = 0; i < 20; i++) begin
      w  = 1'($urandom);
      io = 1'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 12));
      do_txn(w, io, 20'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), ra, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/isa_bus_master.md
# isa_bus_master

Initiator end of the ISA-style bus that the CGA adapter responds to. It converts a single-outstanding request/response interface from the host core into properly sequenced bus cycles: address setup, a read or write strobe with `bus_rdy` wait-state extension and timeout, and a hold phase. For reads it returns the byte the responder drives. It sits between the CPU/bus fabric and the video adapter's `bus_*` pins.

## Interface

Parameters:
- SETUP_CYCLES, 2, cycles address/AEN are stable before the strobe falls (≥1)
- STROBE_CYCLES, 4, minimum strobe-low cycles (≥2; the responder resynchronises strobes)
- HOLD_CYCLES, 1, cycles address and write data are held after the strobe rises (≥1)
- RDY_TIMEOUT, 64, extra strobe cycles allowed while `bus_rdy`=0 (STROBE_CYCLES+RDY_TIMEOUT ≤ 255)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset_l  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  accepting; transfer on req_valid & req_ready
- req_write  in  1  1=write, 0=read
- req_io  in  1  1=I/O space (ior/iow), 0=memory (memr/memw)
- req_addr  in  20  bus address; I/O uses [15:0], upper bits driven 0
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data (FF on write, float or timeout)
- rsp_timeout  out  1  valid with rsp_valid; cycle aborted
- bus_a  out  20  address
- bus_d  out  8  write data
- bus_d_oe  out  1  master drives bus_d
- bus_in  in  8  responder read data
- bus_dir  in  1  responder driving bus_in
- bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  active-low strobes
- bus_aen  out  1  1 outside master cycles (responder decodes disabled)
- bus_rdy  in  1  responder ready; 0 inserts wait states

## Operation

- States: IDLE, SETUP, STROBE, HOLD. One request outstanding.
- IDLE: req_ready=1 (0 while reset_l=0). Strobes high, bus_aen=1, bus_d_oe=0, bus_a holds last value. On accept: latch write/io/addr/wdata, go SETUP.
- SETUP: bus_a=latched addr, bus_aen=0, bus_d=wdata, bus_d_oe=write. After SETUP_CYCLES cycles go STROBE.
- STROBE: exactly one strobe low, selected by {req_io, req_write}. Strobe counter k counts strobe cycles (1 in first). At the end of cycle k: if k ≥ STROBE_CYCLES and bus_rdy=1 → normal end; else if k = STROBE_CYCLES+RDY_TIMEOUT → timeout end; else stay. On either end, capture read data at that edge: bus_dir=1 → bus_in, else 8'hFF; write or timeout → 8'hFF. Go HOLD.
- HOLD: strobe high, bus_a/bus_d/bus_d_oe/bus_aen=0 held for HOLD_CYCLES, then IDLE with rsp_valid=1 for one cycle, rsp_rdata/rsp_timeout as captured.
- rsp_rdata and rsp_timeout hold their value until the next rsp_valid.
- Back-to-back: req_ready=1 in the rsp_valid cycle; a request accepted then starts SETUP next cycle.
- Reset values (every output): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, bus_a=0, bus_d=0, bus_d_oe=0, all strobes=1, bus_aen=1. Reset in any state aborts the cycle on that edge: strobe rises, no rsp_valid issued, latched request discarded.

## Timing

- Accept at edge E0. SETUP occupies cycles 1..S; strobe low in cycles S+1..S+T (T=actual strobe length); HOLD occupies S+T+1..S+T+H; rsp_valid in cycle S+T+H+1.
- Defaults with bus_rdy=1: strobe low cycles 3–6, rsp_valid in cycle 8; request throughput 1 per 8 cycles.
- bus_rdy is sampled only in STROBE cycles with k ≥ STROBE_CYCLES; values earlier are ignored.
- Maximum strobe length: STROBE_CYCLES+RDY_TIMEOUT (68 by default).
- No combinational path from any input to any output; all outputs registered.

## Test plan

- I/O write 0x3D8 data 0x29, bus_rdy=1 → bus_iow_l low exactly cycles 3–6, bus_a=0x003D8, bus_d_oe=1 cycles 1–7, bus_aen=0 cycles 1–7, rsp_valid cycle 8, rsp_rdata=FF, rsp_timeout=0.
- I/O read 0x3DA, responder bus_dir=1, bus_in=0xF9 → bus_ior_l low 4 cycles, bus_d_oe=0 throughout, rsp_rdata=F9.
- Memory read with bus_dir=0 → bus_memr_l low 4 cycles, rsp_rdata=FF, rsp_timeout=0.
- Memory write with bus_rdy=0 during strobe cycles 1–9, 1 at cycle 10 → bus_memw_l low exactly 10 cycles, rsp_valid 6 cycles later than the no-wait case, rsp_timeout=0.
- bus_rdy stuck 0 on read → strobe low 68 cycles, rsp_timeout=1, rsp_rdata=FF; next request proceeds normally.
- reset_l low for 1 cycle in strobe cycle 2 → strobe high, bus_aen=1, req_ready=0 next cycle, no rsp_valid; two back-to-back requests afterward accepted 8 cycles apart with correct data each.
